// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the memory bus arbiter slice.
package mem_arb_pkg;

    localparam int XLEN = 32;
    localparam int BE_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IB = 1'b0,
        OWN_DB = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arb_wdog.sv
// Transaction watchdog: counts busy cycles since the last clear and flags
// expiry during the TIMEOUT_CYC-th enabled cycle.
module mem_arb_wdog #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] count;

    // Busy-cycle counter, restarted at each new transaction and parked at the last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + CW'(1);
        end
    end

    assign expired = enable && (count == LAST);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master (instruction fetch / data) to single-memory bus arbiter with one
// outstanding transaction and a sticky watchdog flag.
// Optional macro ARB_RR_EN: round-robin tie breaking instead of data priority.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ib_req_v,
    output logic            ib_req_r,
    input  logic [XLEN-1:0] ib_req_addr,
    output logic            ib_resp_v,
    input  logic            db_req_v,
    output logic            db_req_r,
    input  logic [XLEN-1:0] db_req_addr,
    input  logic            db_req_we,
    input  logic [XLEN-1:0] db_req_wdata,
    input  logic [BE_W-1:0] db_req_be,
    output logic            db_resp_v,
    output logic [XLEN-1:0] resp_rdata,
    output logic            mem_req_v,
    input  logic            mem_req_r,
    output logic [XLEN-1:0] mem_req_addr,
    output logic            mem_req_we,
    output logic [XLEN-1:0] mem_req_wdata,
    output logic [BE_W-1:0] mem_req_be,
    input  logic            mem_resp_v,
    input  logic [XLEN-1:0] mem_resp_rdata,
    output logic            timeout
);

    state_t          state_q;
    state_t          state_d;
    owner_t          owner_q;
    logic [XLEN-1:0] addr_q;
    logic            we_q;
    logic [XLEN-1:0] wdata_q;
    logic [BE_W-1:0] be_q;
    logic            timeout_q;

    logic pick_db;
    logic idle;
    logic grant_ib;
    logic grant_db;
    logic grant;
    logic expired;
    logic resp_fire;
    logic set_timeout;

`ifdef ARB_RR_EN
    owner_t last_q;

    // Remember who won the most recent grant so the other side wins the next tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= OWN_IB;
        end else if (grant_db) begin
            last_q <= OWN_DB;
        end else if (grant_ib) begin
            last_q <= OWN_IB;
        end
    end

    // Tie goes to whichever requester was not granted last.
    always_comb begin
        pick_db = 1'b0;
        if (db_req_v && ib_req_v) begin
            pick_db = (last_q == OWN_IB);
        end else begin
            pick_db = db_req_v;
        end
    end
`else
    // Data requests always beat fetch requests on a tie.
    always_comb begin
        pick_db = 1'b0;
        pick_db = db_req_v;
    end
`endif

    // Ready is only offered in IDLE and is held low while reset is asserted.
    assign idle     = (state_q == IDLE) && rst_n;
    assign grant_db = idle && db_req_v && pick_db;
    assign grant_ib = idle && ib_req_v && !pick_db;
    assign grant    = grant_ib || grant_db;
    assign ib_req_r = grant_ib;
    assign db_req_r = grant_db;

    mem_arb_wdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_wdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (grant),
        .enable (state_q != IDLE),
        .expired(expired)
    );

    // State register for the single-outstanding transaction FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus memory-side and response outputs; a real response beats the watchdog.
    always_comb begin
        state_d     = state_q;
        mem_req_v   = 1'b0;
        resp_fire   = 1'b0;
        resp_rdata  = '0;
        set_timeout = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                mem_req_v = 1'b1;
                if (expired) begin
                    resp_fire   = 1'b1;
                    set_timeout = 1'b1;
                    state_d     = IDLE;
                end else if (mem_req_r) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_resp_v) begin
                    resp_fire  = 1'b1;
                    resp_rdata = mem_resp_rdata;
                    state_d    = IDLE;
                end else if (expired) begin
                    resp_fire   = 1'b1;
                    set_timeout = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ib_resp_v = resp_fire && (owner_q == OWN_IB);
    assign db_resp_v = resp_fire && (owner_q == OWN_DB);

    // Capture the winning request; fetches are always full-word loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            be_q    <= '0;
            owner_q <= OWN_IB;
        end else if (grant_db) begin
            addr_q  <= db_req_addr;
            we_q    <= db_req_we;
            wdata_q <= db_req_wdata;
            be_q    <= db_req_be;
            owner_q <= OWN_DB;
        end else if (grant_ib) begin
            addr_q  <= ib_req_addr;
            we_q    <= 1'b0;
            wdata_q <= '0;
            be_q    <= {BE_W{1'b1}};
            owner_q <= OWN_IB;
        end
    end

    // Sticky watchdog flag, only cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_q <= 1'b0;
        end else if (set_timeout) begin
            timeout_q <= 1'b1;
        end
    end

    assign timeout       = timeout_q;
    assign mem_req_addr  = addr_q;
    assign mem_req_we    = we_q;
    assign mem_req_wdata = wdata_q;
    assign mem_req_be    = be_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter (TIMEOUT_CYC = 8), honours ARB_RR_EN.
module tb_mem_bus_arbiter;

    localparam int TO = 8;

    logic        clk;
    logic        rst_n;
    logic        ib_req_v;
    logic        ib_req_r;
    logic [31:0] ib_req_addr;
    logic        ib_resp_v;
    logic        db_req_v;
    logic        db_req_r;
    logic [31:0] db_req_addr;
    logic        db_req_we;
    logic [31:0] db_req_wdata;
    logic [3:0]  db_req_be;
    logic        db_resp_v;
    logic [31:0] resp_rdata;
    logic        mem_req_v;
    logic        mem_req_r;
    logic [31:0] mem_req_addr;
    logic        mem_req_we;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_be;
    logic        mem_resp_v;
    logic [31:0] mem_resp_rdata;
    logic        timeout;

    int n_cmp = 0;
    int n_err = 0;
    bit exp_to = 1'b0;
    bit last_db = 1'b0;

    mem_bus_arbiter #(
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ib_req_v      (ib_req_v),
        .ib_req_r      (ib_req_r),
        .ib_req_addr   (ib_req_addr),
        .ib_resp_v     (ib_resp_v),
        .db_req_v      (db_req_v),
        .db_req_r      (db_req_r),
        .db_req_addr   (db_req_addr),
        .db_req_we     (db_req_we),
        .db_req_wdata  (db_req_wdata),
        .db_req_be     (db_req_be),
        .db_resp_v     (db_resp_v),
        .resp_rdata    (resp_rdata),
        .mem_req_v     (mem_req_v),
        .mem_req_r     (mem_req_r),
        .mem_req_addr  (mem_req_addr),
        .mem_req_we    (mem_req_we),
        .mem_req_wdata (mem_req_wdata),
        .mem_req_be    (mem_req_be),
        .mem_resp_v    (mem_resp_v),
        .mem_resp_rdata(mem_resp_rdata),
        .timeout       (timeout)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #500000;
        $display("[TB] FAIL global_timer: observed stall expected finish");
        $fatal(1, "[TB] simulation time limit");
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_ib_req_r"}, ib_req_r, 0);
        check_output({tag, "_db_req_r"}, db_req_r, 0);
        check_output({tag, "_ib_resp_v"}, ib_resp_v, 0);
        check_output({tag, "_db_resp_v"}, db_resp_v, 0);
        check_output({tag, "_resp_rdata"}, resp_rdata, 0);
        check_output({tag, "_mem_req_v"}, mem_req_v, 0);
        check_output({tag, "_mem_req_addr"}, mem_req_addr, 0);
        check_output({tag, "_mem_req_we"}, mem_req_we, 0);
        check_output({tag, "_mem_req_wdata"}, mem_req_wdata, 0);
        check_output({tag, "_mem_req_be"}, mem_req_be, 0);
        check_output({tag, "_timeout"}, timeout, 0);
    endtask

    // One full transaction: present requests, check the grant, then play the memory
    // side cycle by cycle while the model predicts the outcome of each busy cycle.
    task automatic apply_stimulus(input bit ib_v, input bit db_v,
                                  input logic [31:0] ia, input logic [31:0] da,
                                  input bit we, input logic [31:0] wd, input logic [3:0] be,
                                  input int acc_dly, input int rsp_dly, input bit respond,
                                  input logic [31:0] rd, input bit hold);
        bit          w_db;
        bit          in_issue;
        bit          r_v;
        logic [31:0] r_d;
        logic [31:0] e_addr;
        logic [31:0] e_wd;
        logic        e_we;
        logic [3:0]  e_be;
        int          acc_k;
        int          rsp_k;

        ib_req_v       = ib_v;
        db_req_v       = db_v;
        ib_req_addr    = ia;
        db_req_addr    = da;
        db_req_we      = we;
        db_req_wdata   = wd;
        db_req_be      = be;
        mem_req_r      = 1'b0;
        mem_resp_v     = 1'($urandom_range(0, 1));
        mem_resp_rdata = $urandom;

        if (ib_v && db_v) begin
`ifdef ARB_RR_EN
            w_db = !last_db;
`else
            w_db = 1'b1;
`endif
        end else begin
            w_db = db_v;
        end
        last_db = w_db;
        e_addr  = w_db ? da : ia;
        e_we    = w_db ? we : 1'b0;
        e_wd    = w_db ? wd : 32'h0;
        e_be    = w_db ? be : 4'hF;

        #1;
        check_output("grant_ib_req_r", ib_req_r, !w_db);
        check_output("grant_db_req_r", db_req_r, w_db);
        check_output("idle_stray_ib_resp_v", ib_resp_v, 0);
        check_output("idle_stray_db_resp_v", db_resp_v, 0);
        check_output("idle_resp_rdata", resp_rdata, 0);
        @(posedge clk);
        @(negedge clk);
        if (!hold) begin
            if (w_db) db_req_v = 1'b0;
            else      ib_req_v = 1'b0;
        end

        acc_k = acc_dly + 1;
        rsp_k = acc_k + rsp_dly + 1;
        for (int k = 1; k <= TO; k++) begin
            in_issue = (k <= acc_k);
            if (in_issue) begin
                mem_req_r      = (k == acc_k);
                mem_resp_v     = 1'($urandom_range(0, 1));
                mem_resp_rdata = $urandom;
            end else begin
                mem_req_r      = 1'b0;
                mem_resp_v     = respond && (k == rsp_k);
                mem_resp_rdata = mem_resp_v ? rd : $urandom;
            end
            if (!in_issue && respond && (k == rsp_k)) begin
                r_v = 1'b1;
                r_d = rd;
            end else if (k == TO) begin
                r_v    = 1'b1;
                r_d    = 32'h0;
                exp_to = 1'b1;
            end else begin
                r_v = 1'b0;
                r_d = 32'h0;
            end
            #1;
            check_output("busy_mem_req_v", mem_req_v, in_issue);
            if (in_issue) begin
                check_output("mem_req_addr", mem_req_addr, e_addr);
                check_output("mem_req_we", mem_req_we, e_we);
                check_output("mem_req_wdata", mem_req_wdata, e_wd);
                check_output("mem_req_be", mem_req_be, e_be);
            end
            check_output("busy_ib_req_r", ib_req_r, 0);
            check_output("busy_db_req_r", db_req_r, 0);
            check_output("ib_resp_v", ib_resp_v, r_v && !w_db);
            check_output("db_resp_v", db_resp_v, r_v && w_db);
            check_output("resp_rdata", resp_rdata, r_d);
            @(posedge clk);
            @(negedge clk);
            if (r_v) break;
        end
        mem_req_r  = 1'b0;
        mem_resp_v = 1'b0;
        #1;
        check_output("post_mem_req_v", mem_req_v, 0);
        check_output("sticky_timeout", timeout, exp_to);
    endtask

    // Directed sequence followed by a randomized burst, reset tests at the ends.
    initial begin
        rst_n          = 1'b0;
        ib_req_v       = 1'b0;
        ib_req_addr    = '0;
        db_req_v       = 1'b0;
        db_req_addr    = '0;
        db_req_we      = 1'b0;
        db_req_wdata   = '0;
        db_req_be      = '0;
        mem_req_r      = 1'b0;
        mem_resp_v     = 1'b0;
        mem_resp_rdata = '0;
        #1;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // single fetch, response two cycles after acceptance
        apply_stimulus(1, 0, 32'h100, 32'h0, 0, 32'h0, 4'h0, 0, 1, 1, 32'hCAFEF00D, 0);

        // simultaneous requests: data side first in both policies (last grant was fetch)
        apply_stimulus(1, 1, 32'h200, 32'h300, 1, 32'h1234_5678, 4'h3, 0, 0, 1, 32'hA5A5_0001, 0);
        apply_stimulus(1, 0, 32'h200, 32'h0, 0, 32'h0, 4'h0, 1, 0, 1, 32'hA5A5_0002, 0);

        // both held high across four transactions
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1, 1, 32'h1000 + 32'(i), 32'h2000 + 32'(i), 0, 32'hDEAD_0000 + 32'(i),
                           4'hC, 0, 0, 1, 32'h5000 + 32'(i), 1);
        end

        // memory holds off acceptance for five cycles
        apply_stimulus(0, 1, 32'h0, 32'h4444, 1, 32'h9999_8888, 4'h5, 5, 0, 1, 32'h7777, 0);

        // randomized traffic, all responses inside the watchdog window
        for (int i = 0; i < 40; i++) begin
            bit iv;
            bit dv;
            iv = 1'($urandom_range(0, 1));
            dv = 1'($urandom_range(0, 1));
            if (!iv && !dv) dv = 1'b1;
            apply_stimulus(iv, dv, $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom,
                           4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), 1,
                           $urandom, 1'($urandom_range(0, 1)));
        end

        // response arriving in the same cycle the watchdog expires
        apply_stimulus(0, 1, 32'h0, 32'h8888, 0, 32'h0, 4'hF, 3, 3, 1, 32'hBEEF_0012, 0);

        // watchdog expiry in WAIT, then in ISSUE, then normal traffic keeps the flag
        apply_stimulus(1, 0, 32'h600, 32'h0, 0, 32'h0, 4'h0, 1, 0, 0, 32'h0, 0);
        apply_stimulus(0, 1, 32'h0, 32'h700, 1, 32'h1111, 4'h1, 9, 0, 0, 32'h0, 0);
        apply_stimulus(1, 0, 32'h800, 32'h0, 0, 32'h0, 4'h0, 0, 0, 1, 32'h0BAD_CAFE, 0);

        // reset in the middle of WAIT, then a stray memory response
        ib_req_v    = 1'b1;
        ib_req_addr = 32'h900;
        @(posedge clk);
        @(negedge clk);
        ib_req_v  = 1'b0;
        mem_req_r = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mem_req_r = 1'b0;
        rst_n     = 1'b0;
        #1;
        check_all_zero("mid_reset");
        @(posedge clk);
        @(negedge clk);
        rst_n          = 1'b1;
        exp_to         = 1'b0;
        last_db        = 1'b0;
        mem_resp_v     = 1'b1;
        mem_resp_rdata = 32'h5A5A_5A5A;
        #1;
        check_all_zero("stray_resp");
        @(posedge clk);
        @(negedge clk);
        mem_resp_v = 1'b0;
        #1;
        check_all_zero("after_stray");

        // arbiter still functional after reset
        apply_stimulus(1, 1, 32'hA00, 32'hB00, 0, 32'h0, 4'hF, 0, 2, 1, 32'h1357_9BDF, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 64, max cycles ISSUE+WAIT before forced completion.
REQ-002 SHALL have ports:
  clk  in  1  rising-edge clock
  rst_n  in  1  async reset, active low
  ib_req_v  in  1  instruction fetch request valid
  ib_req_r  out  1  fetch request accepted
  ib_req_addr  in  32  fetch byte address
  ib_resp_v  out  1  fetch response valid, one-cycle pulse
  db_req_v  in  1  data request valid
  db_req_r  out  1  data request accepted
  db_req_addr  in  32  data byte address
  db_req_we  in  1  1 = store, 0 = load
  db_req_wdata  in  32  store data
  db_req_be  in  4  store byte enables
  db_resp_v  out  1  data response valid, one-cycle pulse
  resp_rdata  out  32  read data shared by both responses
  mem_req_v  out  1  memory request valid
  mem_req_r  in  1  memory accepts request
  mem_req_addr / mem_req_we / mem_req_wdata / mem_req_be  out  32/1/32/4  latched request fields
  mem_resp_v  in  1  memory response valid
  mem_resp_rdata  in  32  memory read data
  timeout  out  1  sticky watchdog error flag
REQ-003 SHALL use one clock, clk; reset rst_n is asynchronous, active-low.

Function
REQ-004 SHALL implement FSM IDLE -> ISSUE -> WAIT -> IDLE, one transaction outstanding.
REQ-005 IDLE: grantee's req_r SHALL be combinationally 1 while its req_v=1; other req_r=0; req_r=0 in ISSUE/WAIT.
REQ-006 Grant (req_v & req_r) in cycle N SHALL latch addr/we/wdata/be and owner; ib grants latch we=0, be=4'hF, wdata=0; state=ISSUE at N+1.
REQ-007 ISSUE: mem_req_v=1 with latched fields held stable; mem_req_v&mem_req_r moves to WAIT next cycle.
REQ-008 WAIT: mem_resp_v=1 SHALL assert owner's resp_v same cycle, resp_rdata=mem_resp_rdata, return to IDLE next cycle.
REQ-009 Every request incl. stores SHALL complete with exactly one resp_v pulse.
REQ-010 mem_resp_v in IDLE or ISSUE SHALL be ignored.
REQ-011 Watchdog counter cleared on IDLE->ISSUE, increments each ISSUE/WAIT cycle; at TIMEOUT_CYC without response SHALL pulse owner resp_v with resp_rdata=0, set timeout, go IDLE.
REQ-012 Response and timeout in same cycle: response wins, timeout not set.
REQ-013 resp_rdata SHALL be 0 whenever no resp_v asserted.
REQ-014 Simultaneous ib_req_v & db_req_v in IDLE: db wins (fixed priority), unless REQ-018 applies.

Reset
REQ-015 rst_n=0 SHALL immediately force IDLE, clear latched fields, owner, counter, timeout; all outputs 0.
REQ-016 Reset mid-transaction SHALL abandon it with no resp_v; later mem_resp_v ignored per REQ-010.

Configuration
REQ-017 Macro ARB_RR_EN selects arbitration policy.
REQ-018 With ARB_RR_EN defined: on simultaneous requests, requester not granted last wins; last-grant register resets to ib (so db wins first tie). Without: REQ-014 fixed priority, no last-grant register.

Structure
REQ-019 Package mem_arb_pkg SHALL hold state enum (IDLE/ISSUE/WAIT), owner enum (OWN_IB/OWN_DB), XLEN=32, BE_W=4.
REQ-020 Watchdog SHALL be sub-module mem_arb_wdog (clear, enable, expired); no other sub-modules.

Verification
REQ-021 ib_req_v, addr 0x100, mem_req_r=1, mem_resp_v 2 cycles later with 0xCAFEF00D -> mem_req_addr=0x100 we=0 be=F; ib_resp_v one pulse, resp_rdata=0xCAFEF00D.
REQ-022 Both request same cycle, fixed policy -> db granted first, ib second; two separate mem transactions, order db then ib.
REQ-023 ARB_RR_EN, both held high 4 transactions -> grant order db, ib, db, ib.
REQ-024 mem_req_r held 0 for 5 cycles -> mem_req_v and fields stable 5 cycles, req_r both 0 throughout.
REQ-025 TIMEOUT_CYC=8, no mem_resp_v -> owner resp_v with rdata 0 at 8th cycle, timeout stays 1 after later traffic until rst_n.
REQ-026 rst_n low during WAIT, stray mem_resp_v after release -> no resp_v, FSM IDLE, all outputs 0.
